// File: rtl/alu_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_scheduler
// Brief    : Round-robin scheduler that lets two requesters share one 16-bit
//            ALU. It issues a command, waits ALU_LAT cycles, captures the
//            result and overflow flag, returns them on a valid/ready response
//            channel, then drives one CLEAR cycle.
// Options  : ALU_SCHED_ILLEGAL_TRAP_EN - illegal opcodes are answered
//            directly with rsp_err_o = 1 and are never issued to the ALU.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_scheduler #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid_i,
    output logic [1:0]  req_ready_o,
    input  logic [3:0]  req0_opcode_i,
    input  logic [3:0]  req1_opcode_i,
    input  logic [15:0] req0_a_i,
    input  logic [15:0] req0_b_i,
    input  logic [15:0] req1_a_i,
    input  logic [15:0] req1_b_i,
    output logic [3:0]  alu_opcode_o,
    output logic [15:0] alu_a_o,
    output logic [15:0] alu_b_o,
    input  logic [15:0] alu_result_i,
    input  logic        alu_overflow_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [15:0] rsp_data_o,
    output logic        rsp_ovf_o,
    output logic        rsp_err_o
);

    localparam logic [3:0] c_OP_ADD   = 4'b1000;
    localparam logic [3:0] c_OP_SUB   = 4'b1001;
    localparam logic [3:0] c_OP_CLEAR = 4'b1111;
    localparam logic [3:0] c_WAIT_LOAD = 4'(ALU_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_CLR   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        id_q, id_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_ovf_q, rsp_ovf_d;
    logic        rsp_err_q, rsp_err_d;
    logic [3:0]  alu_opcode_q, alu_opcode_d;
    logic [15:0] alu_a_q, alu_a_d;
    logic [15:0] alu_b_q, alu_b_d;

    logic        w_sel;
    logic [1:0]  w_grant;
    logic        w_accept;
    logic [3:0]  w_sel_op;
    logic        w_trap;

    // Round-robin grant: a lone requester wins, on contention the one that was not last wins.
    always_comb begin
        w_sel   = (req_valid_i == 2'b11) ? ~last_q : req_valid_i[1];
        w_grant = (req_valid_i == 2'b00) ? 2'b00 : (w_sel ? 2'b10 : 2'b01);
        req_ready_o = ((state_q == S_IDLE) && !rst) ? w_grant : 2'b00;
        w_accept    = |(req_ready_o & req_valid_i);
        w_sel_op    = w_sel ? req1_opcode_i : req0_opcode_i;
    end

`ifdef ALU_SCHED_ILLEGAL_TRAP_EN
    // Codes 0111 and 1100..1110 have no ALU function and are answered locally.
    assign w_trap = (w_sel_op == 4'b0111) || (w_sel_op == 4'b1100) ||
                    (w_sel_op == 4'b1101) || (w_sel_op == 4'b1110);
`else
    assign w_trap = 1'b0;
`endif

    // Next-state and registered-output logic for the scheduler FSM.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        id_d         = id_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_err_d    = rsp_err_q;
        alu_opcode_d = c_OP_CLEAR;
        alu_a_d      = 16'h0000;
        alu_b_d      = 16'h0000;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    last_d    = w_sel;
                    id_d      = w_sel;
                    op_d      = w_sel_op;
                    a_d       = w_sel ? req1_a_i : req0_a_i;
                    b_d       = w_sel ? req1_b_i : req0_b_i;
                    rsp_err_d = w_trap;
                    if (w_trap) begin
                        // Valid is raised one cycle later from within RESP.
                        rsp_data_d = 16'h0000;
                        rsp_ovf_d  = 1'b0;
                        state_d    = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = c_WAIT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = alu_result_i;
                    rsp_ovf_d   = ((op_q == c_OP_ADD) || (op_q == c_OP_SUB)) && alu_overflow_i;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_CLR;
                end
            end
            S_CLR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The ALU sees the command only while it is being issued or executed.
        if ((state_d == S_ISSUE) || (state_d == S_WAIT)) begin
            alu_opcode_d = op_d;
            alu_a_d      = a_d;
            alu_b_d      = b_d;
        end
    end

    // State and output registers; reset drops any in-flight command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_q       <= 1'b1;
            id_q         <= 1'b0;
            op_q         <= c_OP_CLEAR;
            a_q          <= 16'h0000;
            b_q          <= 16'h0000;
            cnt_q        <= 4'd0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 16'h0000;
            rsp_ovf_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
            alu_opcode_q <= c_OP_CLEAR;
            alu_a_q      <= 16'h0000;
            alu_b_q      <= 16'h0000;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            id_q         <= id_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_err_q    <= rsp_err_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
        end
    end

    assign alu_opcode_o = alu_opcode_q;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = id_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_ovf_o    = rsp_ovf_q;
    assign rsp_err_o    = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_scheduler
// Brief    : Directed self-checking bench. Two schedulers (ALU_LAT = 1 and 3)
//            share the stimulus; each drives its own pipelined ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [3:0]  op0, op1;
    logic [15:0] a0, b0, a1, b1;
    logic        rsp_ready;

    logic [1:0]  rdy1, rdy3;
    logic [3:0]  aop1, aop3;
    logic [15:0] aa1, ab1, aa3, ab3;
    logic [15:0] res1, res3;
    logic        ovf1, ovf3;
    logic        rv1, rv3, rid1, rid3, rovf1, rovf3, rerr1, rerr3;
    logic [15:0] rdat1, rdat3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_op_scheduler #(.ALU_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(rdy1),
        .req0_opcode_i(op0), .req1_opcode_i(op1),
        .req0_a_i(a0), .req0_b_i(b0), .req1_a_i(a1), .req1_b_i(b1),
        .alu_opcode_o(aop1), .alu_a_o(aa1), .alu_b_o(ab1),
        .alu_result_i(res1), .alu_overflow_i(ovf1),
        .rsp_valid_o(rv1), .rsp_ready_i(rsp_ready), .rsp_id_o(rid1),
        .rsp_data_o(rdat1), .rsp_ovf_o(rovf1), .rsp_err_o(rerr1)
    );

    alu_op_scheduler #(.ALU_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(rdy3),
        .req0_opcode_i(op0), .req1_opcode_i(op1),
        .req0_a_i(a0), .req0_b_i(b0), .req1_a_i(a1), .req1_b_i(b1),
        .alu_opcode_o(aop3), .alu_a_o(aa3), .alu_b_o(ab3),
        .alu_result_i(res3), .alu_overflow_i(ovf3),
        .rsp_valid_o(rv3), .rsp_ready_i(rsp_ready), .rsp_id_o(rid3),
        .rsp_data_o(rdat3), .rsp_ovf_o(rovf3), .rsp_err_o(rerr3)
    );

    // ALU reference: {overflow, result}. Overflow is deliberately 1 for
    // non-arithmetic ops so the scheduler's masking is exercised.
    function automatic logic [16:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic        v;
        v = 1'b1;
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: r = ~a;
            4'h3: r = a ^ b;
            4'h4: r = ~(a & b);
            4'h5: r = ~(a | b);
            4'h6: r = ~(a ^ b);
            4'h8: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
            4'h9: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
            4'hA: r = a >> 1;
            4'hB: r = a << 1;
            4'hF: begin r = 16'h0000; v = 1'b0; end
            default: r = 16'hDEAD;
        endcase
        return {v, r};
    endfunction

    // ALU register latency: result appears ALU_LAT edges after the inputs change.
    logic [16:0] p1;
    logic [16:0] p3 [3];
    always @(posedge clk) begin
        p1    <= alu_f(aop1, aa1, ab1);
        p3[0] <= alu_f(aop3, aa3, ab3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign {ovf1, res1} = p1;
    assign {ovf3, res3} = p3[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for an accept on the LAT=1 instance; ncyc counts edges up to and including it.
    task automatic do_accept(output logic gid, output int ncyc);
        logic got;
        got  = 1'b0;
        gid  = 1'b0;
        ncyc = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            if (|(rdy1 & req_valid)) begin
                gid = rdy1[1];
                got = 1'b1;
            end
            tick();
            ncyc++;
        end
        chk("accept_seen", {31'd0, got}, 32'd1);
    endtask

    // Waits for rsp_valid on the LAT=1 instance; lat counts edges waited.
    task automatic wait_rsp(output int lat);
        logic got;
        got = 1'b0;
        lat = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            if (rv1) got = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
        chk("rsp_seen", {31'd0, got}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic gid;
        int   n;
        int   lat;

        rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
        op0 = 4'hF; op1 = 4'hF; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        tick(); tick(); tick();

        // Reset state
        req_valid = 2'b11; #1;
        chk("rst_alu_op",   {28'd0, aop1}, 32'hF);
        chk("rst_alu_a",    {16'd0, aa1},  32'h0);
        chk("rst_alu_b",    {16'd0, ab1},  32'h0);
        chk("rst_rsp_valid",{31'd0, rv1},  32'h0);
        chk("rst_rsp_data", {16'd0, rdat1},32'h0);
        chk("rst_rsp_id",   {31'd0, rid1}, 32'h0);
        chk("rst_rsp_ovf",  {31'd0, rovf1},32'h0);
        chk("rst_rsp_err",  {31'd0, rerr1},32'h0);
        chk("rst_req_ready",{30'd0, rdy1}, 32'h0);
        req_valid = 2'b00; rst = 1'b0;

        // Reset asserted during the 2nd WAIT cycle of the LAT=3 instance
        op0 = 4'h8; a0 = 16'h001E; b0 = 16'h0007;
        op1 = 4'h9; a1 = 16'h0050; b1 = 16'h0010;
        req_valid = 2'b01; #1;
        chk("mw_ready_before", {30'd0, rdy3}, 32'h1);
        tick();
        req_valid = 2'b00;
        chk("mw_issue_op", {28'd0, aop3}, 32'h8);
        tick(); tick();
        chk("mw_wait2_op",    {28'd0, aop3}, 32'h8);
        chk("mw_wait2_valid", {31'd0, rv3},  32'h0);
        req_valid = 2'b11;
        rst = 1'b1; #1;
        chk("mw_rst_op",    {28'd0, aop3}, 32'hF);
        chk("mw_rst_a",     {16'd0, aa3},  32'h0);
        chk("mw_rst_valid", {31'd0, rv3},  32'h0);
        chk("mw_rst_ready", {30'd0, rdy3}, 32'h0);
        tick();
        rst = 1'b0; #1;
        chk("mw_first_grant3", {30'd0, rdy3}, 32'h1);
        chk("mw_first_grant1", {30'd0, rdy1}, 32'h1);

        // Single ADD from requester 0 (both valid, requester 0 wins first)
        do_accept(gid, n);
        req_valid = 2'b00;
        chk("add_grant",     {31'd0, gid},  32'h0);
        chk("add_issue_op",  {28'd0, aop1}, 32'h8);
        chk("add_issue_a",   {16'd0, aa1},  32'h001E);
        chk("add_issue_b",   {16'd0, ab1},  32'h0007);
        chk("add_issue_rdy", {30'd0, rdy1}, 32'h0);
        chk("add_no_early",  {31'd0, rv1},  32'h0);
        wait_rsp(lat);
        chk("add_latency", lat, 32'd2);
        chk("add_data",    {16'd0, rdat1}, 32'h0025);
        chk("add_id",      {31'd0, rid1},  32'h0);
        chk("add_ovf",     {31'd0, rovf1}, 32'h0);
        chk("add_err",     {31'd0, rerr1}, 32'h0);
        chk("add_resp_op", {28'd0, aop1},  32'hF);
        tick();
        chk("add_clr_valid", {31'd0, rv1}, 32'h0);
        chk("add_clr_op",    {28'd0, aop1}, 32'hF);
        chk("add_clr_a",     {16'd0, aa1},  32'h0);

        // Signed overflow on ADD
        op0 = 4'h8; a0 = 16'hBC40; b0 = 16'h9C40; req_valid = 2'b01;
        do_accept(gid, n);
        req_valid = 2'b00;
        wait_rsp(lat);
        chk("ovf_data", {16'd0, rdat1}, 32'h5880);
        chk("ovf_flag", {31'd0, rovf1}, 32'h1);

        // SUB from requester 1 alone
        op1 = 4'h9; a1 = 16'h001E; b1 = 16'h0007; req_valid = 2'b10;
        do_accept(gid, n);
        req_valid = 2'b00;
        chk("sub_grant", {31'd0, gid}, 32'h1);
        wait_rsp(lat);
        chk("sub_data", {16'd0, rdat1}, 32'h0017);
        chk("sub_ovf",  {31'd0, rovf1}, 32'h0);
        chk("sub_id",   {31'd0, rid1},  32'h1);

        // Contention: both valid for 4 operations
        op0 = 4'h0; a0 = 16'h250A; b0 = 16'h0F0F;
        op1 = 4'hB; a1 = 16'hCE67; b1 = 16'h0000;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            do_accept(gid, n);
            chk("cont_grant",   {31'd0, gid}, (i % 2 == 1) ? 32'h1 : 32'h0);
            chk("cont_spacing", n, 32'd3);
            wait_rsp(lat);
            chk("cont_data", {16'd0, rdat1}, (i % 2 == 1) ? 32'h9CCE : 32'h050A);
            chk("cont_id",   {31'd0, rid1},  (i % 2 == 1) ? 32'h1 : 32'h0);
            chk("cont_ovf",  {31'd0, rovf1}, 32'h0);
        end

        // Backpressure: rsp_ready low for 5 cycles with the other requester valid
        do_accept(gid, n);
        rsp_ready = 1'b0;
        chk("bp_grant", {31'd0, gid}, 32'h0);
        wait_rsp(lat);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", {31'd0, rv1},  32'h1);
            chk("bp_data",  {16'd0, rdat1},32'h050A);
            chk("bp_ready", {30'd0, rdy1}, 32'h0);
            tick();
        end
        rsp_ready = 1'b1;
        chk("bp_valid_last", {31'd0, rv1}, 32'h1);
        tick();
        do_accept(gid, n);
        chk("bp_next_grant",   {31'd0, gid}, 32'h1);
        chk("bp_next_spacing", n, 32'd2);
        wait_rsp(lat);
        chk("bp_next_data", {16'd0, rdat1}, 32'h9CCE);

        // Illegal opcode 1101
        op0 = 4'hD; a0 = 16'h1234; b0 = 16'h5678; req_valid = 2'b01;
        do_accept(gid, n);
        req_valid = 2'b00;
`ifdef ALU_SCHED_ILLEGAL_TRAP_EN
        chk("ill_op_held", {28'd0, aop1}, 32'hF);
        wait_rsp(lat);
        chk("ill_latency", lat, 32'd1);
        chk("ill_err",  {31'd0, rerr1}, 32'h1);
        chk("ill_data", {16'd0, rdat1}, 32'h0);
        chk("ill_ovf",  {31'd0, rovf1}, 32'h0);
        chk("ill_op_resp", {28'd0, aop1}, 32'hF);
`else
        chk("ill_op_issued", {28'd0, aop1}, 32'hD);
        wait_rsp(lat);
        chk("ill_latency", lat, 32'd2);
        chk("ill_err",  {31'd0, rerr1}, 32'h0);
        chk("ill_data", {16'd0, rdat1}, 32'hDEAD);
        chk("ill_ovf",  {31'd0, rovf1}, 32'h0);
`endif
        tick(); tick();
        chk("end_idle_valid", {31'd0, rv1}, 32'h0);
        chk("end_idle_op",    {28'd0, aop1}, 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
